// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM pin bundle for the read/write port arbiter.
// slave is the arbiter's view; master is requesters plus SRAM.
`ifndef INTERNAL_BITS
`define INTERNAL_BITS 16
`endif

interface sram_port_arbiter_if #(
  parameter int ADDR_BITS = 13,
  parameter int DATA_BITS = `INTERNAL_BITS
);
  logic [1:0]           rreq;
  logic [ADDR_BITS-1:0] raddr0;
  logic [ADDR_BITS-1:0] raddr1;
  logic [1:0]           rgnt;
  logic [1:0]           rvalid;
  logic [DATA_BITS-1:0] rdata;
  logic [1:0]           wreq;
  logic [ADDR_BITS-1:0] waddr0;
  logic [ADDR_BITS-1:0] waddr1;
  logic [DATA_BITS-1:0] wdata0;
  logic [DATA_BITS-1:0] wdata1;
  logic [1:0]           wgnt;
  logic                 cena;
  logic [ADDR_BITS-1:0] aa;
  logic [DATA_BITS-1:0] qa;
  logic                 cenb;
  logic                 wenb;
  logic [ADDR_BITS-1:0] ab;
  logic [DATA_BITS-1:0] db;

  modport slave (
    input  rreq, raddr0, raddr1,
    input  wreq, waddr0, waddr1,
    input  wdata0, wdata1, qa,
    output rgnt, rvalid, rdata, wgnt,
    output cena, aa, cenb, wenb, ab, db
  );

  modport master (
    output rreq, raddr0, raddr1,
    output wreq, waddr0, waddr1,
    output wdata0, wdata1, qa,
    input  rgnt, rvalid, rdata, wgnt,
    input  cena, aa, cenb, wenb, ab, db
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter for a two-port SRAM: port A read, port B write.
// Registered SRAM pins, fixed two-edge read return, same-cycle bypass.
`ifndef INTERNAL_BITS
`define INTERNAL_BITS 16
`endif

module sram_port_arbiter #(
  parameter int ADDR_BITS = 13,
  parameter int DATA_BITS = `INTERNAL_BITS
) (
  input  logic clk,
  input  logic rst_n,
  sram_port_arbiter_if.slave bus
);
  typedef struct packed {
    logic                 v;
    logic                 id;
    logic                 byp;
    logic [DATA_BITS-1:0] d;
  } rtag_t;

  logic                 rptr, wptr;
  logic [1:0]           rgnt, wgnt;
  logic                 racc, wacc;
  logic                 rid, wid;
  logic [ADDR_BITS-1:0] ra, wa;
  logic [DATA_BITS-1:0] wd;
  logic                 cena_q, cenb_q, wenb_q;
  logic [ADDR_BITS-1:0] aa_q, ab_q;
  logic [DATA_BITS-1:0] db_q;
  rtag_t                s1, s2;

  // lone request wins; under contention the pointer owner wins
  always_comb begin
    rgnt = bus.rreq;
    wgnt = bus.wreq;
    if (&bus.rreq) rgnt = rptr ? 2'b10 : 2'b01;
    if (&bus.wreq) wgnt = wptr ? 2'b10 : 2'b01;
  end

  assign racc = |rgnt;
  assign wacc = |wgnt;
  assign rid  = rgnt[1];
  assign wid  = wgnt[1];
  assign ra   = rid ? bus.raddr1 : bus.raddr0;
  assign wa   = wid ? bus.waddr1 : bus.waddr0;
  assign wd   = wid ? bus.wdata1 : bus.wdata0;

  // pointer hands priority to the requester not just served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= 1'b0;
      wptr <= 1'b0;
    end else begin
      if (racc) rptr <= ~rid;
      if (wacc) wptr <= ~wid;
    end
  end

  // port A pins: enable pulses per accept, address holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cena_q <= 1'b0;
      aa_q   <= '0;
    end else begin
      cena_q <= racc;
      if (racc) aa_q <= ra;
    end
  end

  // port B pins: enable and write strobe together, addr/data hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cenb_q <= 1'b0;
      wenb_q <= 1'b0;
      ab_q   <= '0;
      db_q   <= '0;
    end else begin
      cenb_q <= wacc;
      wenb_q <= wacc;
      if (wacc) begin
        ab_q <= wa;
        db_q <= wd;
      end
    end
  end

  // return tag pipe; same-address write data rides along as bypass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1.v   <= racc;
      s1.id  <= rid;
      s1.byp <= racc & wacc & (ra == wa);
      s1.d   <= wd;
      s2     <= s1;
    end
  end

  assign bus.rgnt   = rgnt;
  assign bus.wgnt   = wgnt;
  assign bus.cena   = cena_q;
  assign bus.aa     = aa_q;
  assign bus.cenb   = cenb_q;
  assign bus.wenb   = wenb_q;
  assign bus.ab     = ab_q;
  assign bus.db     = db_q;
  assign bus.rvalid = {s2.v & s2.id, s2.v & ~s2.id};
  assign bus.rdata  = s2.byp ? s2.d : bus.qa;
endmodule
